div_seq_arbiter: RTL and testbench

Sequential fixed-point divider that serves two requesters from one shared restoring sub-and-shift datapath. It computes A/B as an unsigned quotient with ARG_BIT_WIDTH integer bits and PRECISION fraction bits, retiring one quotient bit per cycle. A round-robin arbiter chooses between the two request ports, and a single response port returns the result tagged with the requester ID. It replaces the fully unrolled combinational divider wherever area matters more than latency.

---
 rtl/div_seq_arbiter_pkg.sv | 12 +
 rtl/div_seq_arbiter_if.sv | 22 ++
 rtl/div_seq_arbiter_step.sv | 18 +
 rtl/div_seq_arbiter.sv | 92 +++++++++
 tb/tb_div_seq_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_arbiter_pkg.sv
// Shared widths, state encoding and quotient type for the two-port
// sequential fixed-point divider.
package div_pkg;
  localparam int ARG_BIT_WIDTH = 32;
  localparam int PRECISION     = 64;
  localparam int QW            = ARG_BIT_WIDTH + PRECISION;
  localparam int CW            = $clog2(QW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  typedef logic [QW-1:0]            quot_t;
  typedef logic [ARG_BIT_WIDTH-1:0] arg_t;
endpackage

// File: rtl/div_seq_arbiter_if.sv
// Request ports for both requesters plus the shared tagged response port.
interface div_seq_arbiter_if;
  import div_pkg::*;

  logic  r0_valid, r0_ready;
  arg_t  r0_a, r0_b;
  logic  r1_valid, r1_ready;
  arg_t  r1_a, r1_b;
  logic  rsp_valid, rsp_ready;
  logic  rsp_id;
  quot_t rsp_q;
  logic  rsp_dz;

  modport master (
    output r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, rsp_ready,
    input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_q, rsp_dz
  );
  modport slave (
    input  r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, rsp_ready,
    output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_q, rsp_dz
  );
endinterface

// File: rtl/div_seq_arbiter_step.sv
// One restoring division step: shift a dividend bit into the remainder and
// subtract the divisor when it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         in_bit,
  input  logic [W-1:0] b,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] t, diff;

  assign t        = {rem, in_bit};
  assign diff     = t - {1'b0, b};
  assign q_bit    = (t >= {1'b0, b});
  assign rem_next = q_bit ? diff[W-1:0] : t[W-1:0];
endmodule

// File: rtl/div_seq_arbiter.sv
// Round-robin two-requester front end feeding one bit-serial restoring
// divider; one quotient bit retires per RUN cycle.
module div_seq_arbiter
  import div_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  div_seq_arbiter_if.slave  bus
);
  div_state_t    state, state_nxt;
  logic          last_grant, grant, armed, idle_ok, acc;
  logic          id, dz, q_bit;
  arg_t          rem, rem_next, a_sh, b_r, acc_a, acc_b;
  quot_t         q;
  logic [CW-1:0] cnt;

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    grant = ~last_grant;
    if (bus.r0_valid && !bus.r1_valid)      grant = 1'b0;
    else if (bus.r1_valid && !bus.r0_valid) grant = 1'b1;
  end

  // armed keeps both readies low until the first edge after reset release.
  assign idle_ok      = armed && (state == IDLE);
  assign bus.r0_ready = idle_ok && !grant;
  assign bus.r1_ready = idle_ok && grant;
  assign acc   = (bus.r0_valid && bus.r0_ready) || (bus.r1_valid && bus.r1_ready);
  assign acc_a = grant ? bus.r1_a : bus.r0_a;
  assign acc_b = grant ? bus.r1_b : bus.r0_b;

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_q     = q;
  assign bus.rsp_id    = id;
  assign bus.rsp_dz    = dz;

  div_step #(.W(ARG_BIT_WIDTH)) u_step (
    .rem      (rem),
    .in_bit   (a_sh[ARG_BIT_WIDTH-1]),
    .b        (b_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = (acc_b == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dividend stream {A, 0...} is produced by shifting A left; once A is
  // exhausted zeros feed in, which supplies the fraction bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      last_grant <= 1'b1;
      id         <= 1'b0;
      dz         <= 1'b0;
      rem        <= '0;
      a_sh       <= '0;
      b_r        <= '0;
      q          <= '0;
      cnt        <= '0;
    end else begin
      armed <= 1'b1;
      if (acc) begin
        a_sh       <= acc_a;
        b_r        <= acc_b;
        id         <= grant;
        last_grant <= grant;
        rem        <= '0;
        q          <= '0;
        cnt        <= CW'(QW-1);
        dz         <= (acc_b == '0);
      end else if (state == RUN) begin
        rem  <= rem_next;
        q    <= {q[QW-2:0], q_bit};
        a_sh <= {a_sh[ARG_BIT_WIDTH-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_div_seq_arbiter.sv
// Scoreboard bench for div_seq_arbiter: expected responses come from a
// wide-division model at accept time and are compared at response time.
module tb_div_seq_arbiter;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_arbiter_if bus();

  div_seq_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic  id;
    quot_t q;
    logic  dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t model(input logic id, input arg_t a, input arg_t b);
    exp_t  e;
    quot_t num;
    e.id = id;
    if (b == '0) begin
      e.q  = '0;
      e.dz = 1'b1;
    end else begin
      num  = {a, {PRECISION{1'b0}}};
      e.q  = num / QW'(b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_idle();
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic issue(input logic id, input arg_t a, input arg_t b,
                       output int waited, output logic ok);
    if (id) begin bus.r1_a = a; bus.r1_b = b; bus.r1_valid = 1'b1; end
    else    begin bus.r0_a = a; bus.r0_b = b; bus.r0_valid = 1'b1; end
    waited = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (id ? bus.r1_ready : bus.r0_ready) begin ok = 1'b1; break; end
      waited++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout id=%0d got no ready, required ready within 300 cycles", id);
    end else begin
      @(posedge clk); #1;
      sb.push_back(model(id, a, b));
    end
    if (id) bus.r1_valid = 1'b0; else bus.r0_valid = 1'b0;
  endtask

  // Waits for rsp_valid; lat is in cycles after the accept edge (edge count + 1).
  task automatic wait_rsp(output logic got, output int lat, output exp_t e);
    got = 1'b0;
    lat = 0;
    e = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1'b1; break; end
      lat++;
    end
    lat = lat + 1;
    if (sb.size() != 0) e = sb.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL rsp_timeout got no rsp_valid, required one within 400 cycles");
    end
  endtask

  task automatic test_reset();
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_dz, bus.rsp_q} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got r0r=%b r1r=%b v=%b q=%h, required all 0",
               bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_q);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL ready_masked got %b%b, required 00 before first edge", bus.r0_ready, bus.r1_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL first_tie got r0r=%b r1r=%b, required r0r=1 r1r=0", bus.r0_ready, bus.r1_ready);
    end
    drive_idle();
  endtask

  task automatic test_basic_r0();
    int w; logic ok, got; int lat; exp_t e;
    issue(1'b0, 32'd100, 32'd7, w, ok);
    wait_rsp(got, lat, e);
    checks++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e) begin
      failures++;
      $display("FAIL basic_r0 got id=%0d q=%h dz=%b, required id=%0d q=%h dz=%b",
               bus.rsp_id, bus.rsp_q, bus.rsp_dz, e.id, e.q, e.dz);
    end
    checks++;
    if (bus.rsp_q !== {32'd14, 64'h4924924924924924}) begin
      failures++;
      $display("FAIL basic_r0_const got q=%h, required %h", bus.rsp_q, {32'd14, 64'h4924924924924924});
    end
    checks++;
    if (lat != QW + 1) begin
      failures++;
      $display("FAIL basic_latency got %0d, required %0d", lat, QW + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r1();
    arg_t ta[2] = '{32'd1, 32'hFFFF_FFFF};
    arg_t tb[2] = '{32'd3, 32'd1};
    quot_t tq[2] = '{{32'd0, 64'h5555555555555555}, {32'hFFFF_FFFF, 64'h0}};
    int w; logic ok, got; int lat; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, ta[k], tb[k], w, ok);
      wait_rsp(got, lat, e);
      checks++;
      if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e || bus.rsp_q !== tq[k]) begin
        failures++;
        $display("FAIL r1_result[%0d] got id=%0d q=%h dz=%b, required id=1 q=%h dz=0",
                 k, bus.rsp_id, bus.rsp_q, bus.rsp_dz, tq[k]);
      end
      checks++;
      if (lat != QW + 1) begin
        failures++;
        $display("FAIL r1_latency[%0d] got %0d, required %0d", k, lat, QW + 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int w; logic ok, got; int lat; exp_t e;
    issue(1'b0, 32'd5, 32'd0, w, ok);
    wait_rsp(got, lat, e);
    checks++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== {1'b0, {QW{1'b0}}, 1'b1} || e.dz !== 1'b1) begin
      failures++;
      $display("FAIL div_zero got id=%0d q=%h dz=%b, required id=0 q=0 dz=1",
               bus.rsp_id, bus.rsp_q, bus.rsp_dz);
    end
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL dz_latency got %0d, required 1", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic got; int lat; exp_t e; logic gid; logic seen;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.r0_a = 32'd100; bus.r0_b = 32'd7;
    bus.r1_a = 32'd1;   bus.r1_b = 32'd3;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      gid = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.r0_ready || bus.r1_ready) begin seen = 1'b1; gid = bus.r1_ready; break; end
      end
      checks++;
      if (!seen || (bus.r0_ready && bus.r1_ready) || gid !== t[0]) begin
        failures++;
        $display("FAIL b2b_grant[%0d] got r0r=%b r1r=%b, required grant %0d only",
                 t, bus.r0_ready, bus.r1_ready, t[0]);
      end
      sb.push_back(gid ? model(1'b1, bus.r1_a, bus.r1_b) : model(1'b0, bus.r0_a, bus.r0_b));
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
        failures++;
        $display("FAIL b2b_pulse[%0d] got r0r=%b r1r=%b, required 00", t, bus.r0_ready, bus.r1_ready);
      end
      wait_rsp(got, lat, e);
      checks++;
      if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e || bus.rsp_id !== t[0]) begin
        failures++;
        $display("FAIL b2b_rsp[%0d] got id=%0d q=%h, required id=%0d q=%h",
                 t, bus.rsp_id, bus.rsp_q, e.id, e.q);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    int w; logic ok, got; int lat; exp_t e; int bad;
    bus.rsp_ready = 1'b0;
    issue(1'b1, 32'd22, 32'd5, w, ok);
    wait_rsp(got, lat, e);
    checks++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e) begin
      failures++;
      $display("FAIL bp_rsp got id=%0d q=%h, required id=%0d q=%h", bus.rsp_id, bus.rsp_q, e.id, e.q);
    end
    bus.r0_a = 32'd9; bus.r0_b = 32'd4; bus.r0_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_q !== e.q || bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b q=%h r0r=%b r1r=%b, required v=1 q=%h readies 0",
                 c, bus.rsp_valid, bus.rsp_q, bus.r0_ready, bus.r1_ready, e.q);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'd9, 32'd4, w, ok);
    checks++;
    if (!ok || w != 0) begin
      failures++;
      $display("FAIL bp_next_accept got wait=%0d, required 0", w);
    end
    wait_rsp(got, lat, e);
    checks++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e) begin
      failures++;
      $display("FAIL bp_second got id=%0d q=%h, required id=%0d q=%h", bus.rsp_id, bus.rsp_q, e.id, e.q);
    end
    @(posedge clk); #1;
    bad = 0;
  endtask

  task automatic test_reset_mid_run();
    int w; logic ok, got; int lat; exp_t e;
    issue(1'b0, 32'd100, 32'd7, w, ok);
    repeat (40) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_valid got %b, required 0", bus.rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_dz, bus.rsp_q} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got v=%b q=%h, required all 0", bus.rsp_valid, bus.rsp_q);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 32'd1, 32'd3, w, ok);
    wait_rsp(got, lat, e);
    checks++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_dz} !== e || lat != QW + 1) begin
      failures++;
      $display("FAIL post_abort_r1 got id=%0d q=%h lat=%0d, required id=1 q=%h lat=%0d",
               bus.rsp_id, bus.rsp_q, lat, e.q, QW + 1);
    end
    @(posedge clk); #1;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL post_abort_tie got r0r=%b r1r=%b, required r0r=1 r1r=0", bus.r0_ready, bus.r1_ready);
    end
    drive_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic_r0();
    test_r1();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
